axil_rd_slice: RTL
==================

// Module: axil_rd_slice
// PURPOSE
//  Registered AXI4-Lite read-channel slice, upstream of the slave read FSM.
//  Cuts timing on AR (master->slave) and, optionally, R (slave->master) paths.
//  Full throughput (1 transfer/cycle per channel), no combinational in->out paths.
//  Payload and ordering preserved exactly; no protocol interpretation.
// PARAMETERS
//  DATA_WIDTH  32  RDATA width in bits
//  ADDR_WIDTH  6   ARADDR width in bits
// PORTS
//  CLK         in   1           clock; all logic on rising edge
//  RST         in   1           one clock; reset is synchronous and active-high
//  S_ARVALID   in   1           read address valid from master
//  S_ARREADY   out  1           read address ready to master (registered)
//  S_ARADDR    in   ADDR_WIDTH  read address from master
//  S_ARPROT    in   3           protection attributes from master
//  M_ARVALID   out  1           read address valid to slave (registered)
//  M_ARREADY   in   1           read address ready from slave
//  M_ARADDR    out  ADDR_WIDTH  registered read address to slave
//  M_ARPROT    out  3           registered protection attributes to slave
//  M_RVALID    in   1           read data valid from slave
//  M_RREADY    out  1           read data ready to slave
//  M_RDATA     in   DATA_WIDTH  read data from slave
//  M_RRESP     in   2           read response from slave
//  S_RVALID    out  1           read data valid to master
//  S_RREADY    in   1           read data ready from master
//  S_RDATA     out  DATA_WIDTH  read data to master
//  S_RRESP     out  2           read response to master
// BEHAVIOUR
//  Reset (RST=1 at edge): every *VALID out = 0, every *READY out = 1, state EMPTY,
//   payload regs = 0. Reset mid-operation discards buffered beats, no replay.
//  Handshake: transfer iff VALID & READY on same edge. VALID, once high, holds
//   with stable payload until accepted (output side honours this unconditionally).
//  Per channel, 2-entry skid buffer (main + skid reg), state enum:
//   EMPTY: out VALID=0, in READY=1. in_hs -> BUSY (load main).
//   BUSY : out VALID=1, in READY=1.
//          in_hs & !out_hs -> FULL (load skid); !in_hs & out_hs -> EMPTY;
//          in_hs & out_hs  -> BUSY (reload main, back-to-back).
//   FULL : out VALID=1, in READY=0. out_hs -> BUSY (skid -> main).
//  Latency: in handshake at edge N -> out VALID high after edge N (1 cycle).
//  Out READY deasserted only in FULL; in FULL no input is sampled.
//  Out VALID and in READY are flop outputs; no in->out comb path.
//  Beats leave in acceptance order; at most 2 beats held per channel.
//  Slave-side RRESP/RDATA pass unchanged; no width conversion or arithmetic.
// CONFIGURATION
//  AXIL_RD_SLICE_R_REG_EN defined: R channel uses skid buffer as above (+1 cycle).
//  Not defined: R channel pure wires: S_RVALID=M_RVALID, M_RREADY=S_RREADY,
//   S_RDATA=M_RDATA, S_RRESP=M_RRESP; AR channel always registered.
// STRUCTURE
//  Package axil_pkg: resp_t enum (OKAY=2'b00, EXOKAY=01, SLVERR=10, DECERR=11),
//   skid_state_t enum {EMPTY, BUSY, FULL}, PROT_WIDTH=3 constant.
//  Sub-module axil_skid_buf #(WIDTH): generic valid/ready skid buffer holding the
//   FSM and both regs; instantiated once for AR {ARADDR,ARPROT}, once for R
//   {RDATA,RRESP} under AXIL_RD_SLICE_R_REG_EN.
// TESTING
//  1 Single read: S_ARADDR=6'h0C, M_ARREADY=1 -> M_ARVALID=1 one cycle later,
//    M_ARADDR=6'h0C; S_RDATA=32'hDEADBEEF, S_RRESP=OKAY returned unchanged.
//  2 Back-to-back: S_ARVALID=1 for 8 cycles, addrs 0..7, M_ARREADY=1 ->
//    8 transfers in 8 consecutive cycles, S_ARREADY never drops, order kept.
//  3 Backpressure: M_ARREADY=0, two AR beats 6'h10, 6'h14 -> state FULL,
//    S_ARREADY=0 next cycle; release -> 6'h10 then 6'h14, nothing lost.
//  4 R stall: S_RREADY=0 for 5 cycles, M_RRESP=SLVERR, M_RDATA=32'h1234 ->
//    S_RVALID held, S_RDATA/S_RRESP stable; M_RREADY=0 once two beats held.
//  5 Reset mid-burst: RST=1 one cycle while FULL -> next cycle all VALID=0,
//    READY=1, state EMPTY; buffered beats never appear on output side.
//  6 Macro off: R channel zero-latency; M_RVALID->S_RVALID same cycle.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite read-channel slice.
package axil_pkg;

  localparam int unsigned PROT_WIDTH = 3;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    EMPTY,
    BUSY,
    FULL
  } skid_state_t;

endpackage

// File: rtl/axil_skid_buf.sv
// Two-entry valid/ready skid buffer: full throughput, registered valid and ready,
// no combinational path from either input side to the other.
module axil_skid_buf
  import axil_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             valid_q, ready_q;
  logic             in_hs, out_hs;

  assign in_hs       = in_valid_i & ready_q;
  assign out_hs      = valid_q & out_ready_i;
  assign in_ready_o  = ready_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = main_q;

  // Next state and register loads; main always holds the oldest beat.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_hs) begin
          state_d = BUSY;
          main_d  = in_data_i;
        end
      end
      BUSY: begin
        if (in_hs && !out_hs) begin
          state_d = FULL;
          skid_d  = in_data_i;
        end else if (!in_hs && out_hs) begin
          state_d = EMPTY;
        end else if (in_hs && out_hs) begin
          main_d = in_data_i;
        end
      end
      FULL: begin
        if (out_hs) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State and payload registers; valid/ready are decoded from the next state
  // so both handshake outputs come straight from flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d != EMPTY);
      ready_q <= (state_d != FULL);
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/axil_rd_slice.sv
// AXI4-Lite read-channel register slice. AR is always registered through a skid
// buffer; define AXIL_RD_SLICE_R_REG_EN to register R too, otherwise R is wired
// straight through with zero latency.
module axil_rd_slice
  import axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  S_ARVALID,
  output logic                  S_ARREADY,
  input  logic [ADDR_WIDTH-1:0] S_ARADDR,
  input  logic [2:0]            S_ARPROT,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,
  output logic [ADDR_WIDTH-1:0] M_ARADDR,
  output logic [2:0]            M_ARPROT,
  input  logic                  M_RVALID,
  output logic                  M_RREADY,
  input  logic [DATA_WIDTH-1:0] M_RDATA,
  input  logic [1:0]            M_RRESP,
  output logic                  S_RVALID,
  input  logic                  S_RREADY,
  output logic [DATA_WIDTH-1:0] S_RDATA,
  output logic [1:0]            S_RRESP
);

  localparam int unsigned ArWidth   = ADDR_WIDTH + PROT_WIDTH;
  localparam int unsigned RespWidth = $bits(resp_t);

  axil_skid_buf #(
    .WIDTH (ArWidth)
  ) u_ar_buf (
    .clk_i       (CLK),
    .rst_i       (RST),
    .in_valid_i  (S_ARVALID),
    .in_ready_o  (S_ARREADY),
    .in_data_i   ({S_ARADDR, S_ARPROT}),
    .out_valid_o (M_ARVALID),
    .out_ready_i (M_ARREADY),
    .out_data_o  ({M_ARADDR, M_ARPROT})
  );

`ifdef AXIL_RD_SLICE_R_REG_EN
  localparam int unsigned RWidth = DATA_WIDTH + RespWidth;

  axil_skid_buf #(
    .WIDTH (RWidth)
  ) u_r_buf (
    .clk_i       (CLK),
    .rst_i       (RST),
    .in_valid_i  (M_RVALID),
    .in_ready_o  (M_RREADY),
    .in_data_i   ({M_RDATA, M_RRESP}),
    .out_valid_o (S_RVALID),
    .out_ready_i (S_RREADY),
    .out_data_o  ({S_RDATA, S_RRESP})
  );
`else
  assign S_RVALID = M_RVALID;
  assign M_RREADY = S_RREADY;
  assign S_RDATA  = M_RDATA;
  assign S_RRESP  = M_RRESP[RespWidth-1:0];
`endif

endmodule
